// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus slave: word RAM with a program-load port plus a memory-mapped
// 8N1 serial transmitter fed through a small byte FIFO.
module cpu_bus_ctrl #(
    parameter int          DEPTH        = 256,
    parameter logic [31:0] IO_BASE      = 32'hFFFF0,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 16,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   address,
    input  logic [31:0]   datao,
    input  logic          rw,
    output logic [31:0]   data,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic          tx,
    output logic          tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [31:0]   ram [DEPTH];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          overflow_q, overflow_d;
    logic          wr_prev_q;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic ram_hit, tx_hit, st_hit, wr_strobe, push, push_ok, pop;
    logic fifo_full, fifo_empty, baud_end, ovf_set, ovf_clr;

    assign ram_hit    = (address < 32'(DEPTH));
    assign tx_hit     = (address == IO_BASE);
    assign st_hit     = (address == (IO_BASE + 32'd1));
    assign wr_strobe  = ~rw & tx_hit;
    assign push       = wr_strobe & ~wr_prev_q;
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == {CW{1'b0}});
    assign baud_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign tx         = tx_q;
    assign tx_busy    = busy_q;

    // Combinational read mux; TXDATA and unmapped addresses read as zero
    always_comb begin
        data = 32'h0000_0000;
        if (ram_hit) begin
            data = ram[address[AW-1:0]];
        end else if (st_hit) begin
            data = {28'h000_0000, overflow_q, fifo_full, fifo_empty, busy_q};
        end else begin
            data = 32'h0000_0000;
        end
    end

    // RAM write ports; the program-load write is last so it wins on a shared word
    always_ff @(posedge clock) begin
        if (~rw && ram_hit) begin
            ram[address[AW-1:0]] <= datao;
        end
        if (prog_we) begin
            ram[prog_addr] <= prog_data;
        end
    end

    // Transmitter FSM: pops only from the registered count, so a fresh push waits one clock
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                    baud_d  = {BW{1'b0}};
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = {BW{1'b0}};
                    // Chain straight into the next start bit so queued bytes leave back-to-back
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = {BW{1'b0}};
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO survives only when a pop frees a slot
    always_comb begin
        push_ok    = push & (~fifo_full | pop);
        ovf_set    = push & fifo_full & ~pop;
        ovf_clr    = ~rw & st_hit & datao[3];
        count_d    = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
        wr_ptr_d   = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO storage needs no reset: the pointers decide what is valid
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= datao[7:0];
        end
    end

    // Control and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            overflow_q <= 1'b0;
            wr_prev_q  <= 1'b0;
            baud_q     <= {BW{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            wr_prev_q  <= wr_strobe;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: directed scenarios plus random traffic, checked every
// cycle against a frame-level model (byte queue + time offset within a frame).
module tb_cpu_bus_ctrl;
    localparam int          DEPTH   = 256;
    localparam int          AW      = 8;
    localparam logic [31:0] IO_BASE = 32'hFFFF0;
    localparam int          FD      = 4;
    localparam int          CPB     = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   address, datao, data;
    logic          rw, prog_we, tx, tx_busy;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    logic [7:0]  mq [$];
    logic [7:0]  m_cur;
    int          m_off;
    bit          m_busy, m_ovf, m_prev;
    logic [31:0] mram [DEPTH];
    bit          mvalid [DEPTH];

    cpu_bus_ctrl #(.DEPTH(DEPTH), .IO_BASE(IO_BASE), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .address(address), .datao(datao), .rw(rw),
        .data(data), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = m_off / CPB;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    function automatic logic [31:0] exp_status();
        return {28'h0, m_ovf, (mq.size() == FD), (mq.size() == 0), m_busy};
    endfunction

    task automatic model_step();
        bit strobe, push, popped, set, clr;
        int cnt;
        strobe = (rw == 1'b0) && (address == IO_BASE);
        push   = strobe && !m_prev;
        m_prev = strobe;
        cnt    = mq.size();
        popped = 1'b0;
        if (m_busy) begin
            m_off++;
            if (m_off == 10 * CPB) begin
                if (cnt > 0) begin
                    m_cur = mq.pop_front(); m_off = 0; popped = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end else if (cnt > 0) begin
            m_cur = mq.pop_front(); m_off = 0; m_busy = 1'b1; popped = 1'b1;
        end
        set = 1'b0;
        if (push) begin
            if (cnt < FD || popped) mq.push_back(datao[7:0]);
            else set = 1'b1;
        end
        clr = (rw == 1'b0) && (address == IO_BASE + 32'd1) && datao[3];
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (rw == 1'b0 && address < DEPTH) begin
            mram[address[AW-1:0]] = datao; mvalid[address[AW-1:0]] = 1'b1;
        end
        if (prog_we) begin
            mram[prog_addr] = prog_data; mvalid[prog_addr] = 1'b1;
        end
    endtask

    // reference model advances on every clock edge and clears on reset
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete(); m_busy = 1'b0; m_off = 0; m_ovf = 1'b0; m_prev = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // compare process: outputs checked against the model on every falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("tx_line", {31'h0, tx}, {31'h0, exp_tx()});
                chk("tx_busy", {31'h0, tx_busy}, {31'h0, m_busy});
                if (address < DEPTH) begin
                    if (mvalid[address[AW-1:0]]) chk("ram_read", data, mram[address[AW-1:0]]);
                end else if (address == IO_BASE + 32'd1) begin
                    chk("status_read", data, exp_status());
                end else begin
                    chk("zero_read", data, 32'h0);
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        rw = 1'b0; address = IO_BASE; datao = {24'h0, b};
        step();
        rw = 1'b1; address = IO_BASE + 32'd1;
        step();
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n;
        n = 0;
        while (tx_busy && n < maxc) begin
            step();
            n++;
        end
        chk(nm, {31'h0, tx_busy}, 32'h0);
    endtask

    logic [9:0]  frame;
    logic [31:0] odd_addr [5];

    initial begin
        reset = 1'b1; rw = 1'b1; address = 32'h0; datao = 32'h0;
        prog_we = 1'b0; prog_addr = '0; prog_data = 32'h0;
        odd_addr[0] = IO_BASE; odd_addr[1] = IO_BASE + 32'd1; odd_addr[2] = IO_BASE + 32'd2;
        odd_addr[3] = 32'h100; odd_addr[4] = 32'hFFFF_FFFF;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // T1 reset state
        step();
        chk("t1_tx", {31'h0, tx}, 32'h1);
        chk("t1_busy", {31'h0, tx_busy}, 32'h0);
        address = IO_BASE + 32'd1; #1;
        chk("t1_status", data, 32'h0000_0002);
        address = 32'(DEPTH); #1;
        chk("t1_unmapped", data, 32'h0);

        // T2 RAM
        prog_we = 1'b1; prog_addr = 8'd3; prog_data = 32'h1234_5678;
        step();
        prog_we = 1'b0; rw = 1'b0; address = 32'd5; datao = 32'hDEAD_BEEF;
        step();
        rw = 1'b1; address = 32'd3; #1;
        chk("t2_ram3", data, 32'h1234_5678);
        address = 32'd5; #1;
        chk("t2_ram5", data, 32'hDEAD_BEEF);
        prog_we = 1'b1; prog_addr = 8'd7; prog_data = 32'hCAFE_0007;
        rw = 1'b0; address = 32'd7; datao = 32'h1111_1111;
        step();
        prog_we = 1'b0; rw = 1'b1; #1;
        chk("t2_prog_wins", data, 32'hCAFE_0007);

        // T3 single frame of 0x55
        rw = 1'b0; address = IO_BASE; datao = 32'h55;
        step();
        rw = 1'b1; address = 32'd3;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t3_frame_bit", {31'h0, tx}, {31'h0, frame[i/4]});
        end
        chk("t3_busy_end", {31'h0, tx_busy}, 32'h1);
        step();
        chk("t3_busy_fall", {31'h0, tx_busy}, 32'h0);
        chk("t3_idle_high", {31'h0, tx}, 32'h1);

        // T4 FIFO fill, overflow, clear, drain
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4); push_byte(8'hA5);
        chk("t4_full", data, 32'h0000_0005);
        push_byte(8'hA6);
        chk("t4_overflow", data, 32'h0000_000D);
        rw = 1'b0; address = IO_BASE + 32'd1; datao = 32'h8;
        step();
        rw = 1'b1;
        chk("t4_clear", data, 32'h0000_0005);
        wait_idle(6 * 40 + 20, "t4_drain_timeout");
        chk("t4_after", data, 32'h0000_0002);

        // T5 held strobe pushes once
        rw = 1'b0; address = IO_BASE; datao = 32'h3C;
        step(); step(); step();
        rw = 1'b1; address = IO_BASE + 32'd1; #1;
        chk("t5_one_push", data, 32'h0000_0003);
        wait_idle(100, "t5_drain_timeout");
        chk("t5_after", data, 32'h0000_0002);

        // T6 async reset mid-frame with bytes queued
        push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
        repeat (17) step();
        reset = 1'b0; #1;
        chk("t6_tx_async", {31'h0, tx}, 32'h1);
        chk("t6_busy_async", {31'h0, tx_busy}, 32'h0);
        step(); step();
        reset = 1'b1; #1;
        chk("t6_status", data, 32'h0000_0002);
        repeat (100) step();
        chk("t6_no_frames", {31'h0, tx}, 32'h1);
        chk("t6_no_busy", {31'h0, tx_busy}, 32'h0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rw = 1'b1; prog_we = 1'b0;
            address = 32'($urandom_range(0, 15)); datao = $urandom;
            case ($urandom_range(0, 11))
                4: rw = 1'b0;
                5: if ($urandom_range(0, 1) == 0) begin rw = 1'b0; address = IO_BASE; end
                6: begin rw = 1'b0; address = IO_BASE + 32'd1; end
                7: address = odd_addr[$urandom_range(0, 4)];
                8: begin
                    prog_we = 1'b1; prog_addr = 8'($urandom_range(0, 15)); prog_data = $urandom;
                    if ($urandom_range(0, 1) == 1) begin rw = 1'b0; address = {24'h0, prog_addr}; end
                end
                default: ;
            endcase
            step();
        end
        rw = 1'b1; prog_we = 1'b0; address = IO_BASE + 32'd1;
        wait_idle((FD + 2) * 40 + 20, "rand_drain_timeout");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
